instr_queue: RTL and testbench
==============================

# instr_queue

Circular instruction buffer between the fetcher and the compressed/full-width decoder. It absorbs fetched instruction words with their PCs and presents the oldest entry to the decoder. It pops an entry when the decoder issues it and discards all entries on a branch-misprediction flush. It decouples fetch bandwidth from issue stalls caused by RoB, RS or LSB being full.

## Interface
Parameters:
- IQ_SIZE_WIDTH, default 3: log2 of the entry count (8 entries).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-low reset (rst==0 at a rising edge resets).
- rdy, input, 1: global enable; when 0, all state holds and all inputs are ignored.
- flush, input, 1: misprediction clear from RoB.
- fetch_valid, input, 1: fetcher presents a word this cycle.
- fetch_instr, input, 32: instruction word; a 16-bit instruction sits in [15:0].
- fetch_addr, input, 32: PC of fetch_instr.
- queue_full, output, 1: count == 2^IQ_SIZE_WIDTH; fetcher must not present while high.
- dec_ready, output, 1: head entry valid (decoder instr_ready).
- dec_instr, output, 32: head instruction.
- dec_addr, output, 32: head PC.
- dec_is_c, output, 1: dec_instr[1:0] != 2'b11.
- dec_issued, input, 1: decoder consumes head this cycle (its updating_instr_issued).
- count, output, IQ_SIZE_WIDTH+1: occupancy.

## Operation
- Storage: 2^IQ_SIZE_WIDTH entries of {instr[31:0], addr[31:0]}. Head and tail pointers are IQ_SIZE_WIDTH bits wide and wrap modulo depth with natural overflow. count is one bit wider.
- push = rdy && fetch_valid && !queue_full && !flush. Writes the entry at tail; tail+1.
- pop = rdy && dec_issued && dec_ready && !flush. Advances head by 1.
- push && pop in the same cycle: count unchanged, both pointers advance. On a full queue, push is blocked even if pop is asserted.
- flush (rdy=1): head=tail=count=0 at the edge. Flush overrides same-cycle push and pop. Entry contents may remain stale.
- dec_issued while dec_ready=0 is ignored. fetch_valid while queue_full=1 drops the word; this is a fetcher protocol error and is flagged by assertion in the bench.
- Outputs are combinational from registered state: dec_ready=(count!=0); dec_instr and dec_addr read mem[head]; queue_full=(count==depth).
- Reset: head, tail and count = 0. All mem entries = 0. Therefore dec_ready=0, queue_full=0, dec_instr=0, dec_addr=0, dec_is_c=1, count=0.

## Timing
- Push-to-visible latency: 1 cycle. A word pushed at edge N appears as dec_ready/dec_instr after edge N. Reduced to 0 with bypass (see Configuration).
- Pop takes effect at the edge. The next entry is presented after that edge, so back-to-back issue of one instruction per cycle is sustained.
- queue_full deasserts in the cycle after the pop edge. The fetcher may push at the next edge.
- Mid-operation reset discards all entries regardless of rdy.
- Throughput: 1 push and 1 pop per cycle.

## Configuration
- IQ_BYPASS_EN defined:
  - When count==0 and fetch_valid=1 (rdy=1, no flush), the fetch inputs drive dec_ready=1, dec_instr and dec_addr combinationally.
  - If dec_issued is high in that same cycle, the word is consumed and not written; count stays 0.
  - Otherwise the word is written normally.
- IQ_BYPASS_EN undefined: no combinational path from fetch inputs to decoder outputs; 1-cycle latency always.

## Structure
- Define IQ_SIZE_WIDTH as a `define in config.v, next to ROB_SIZE_WIDTH, so the fetcher can size its own full logic.
- One sub-module, iq_ram: 2^IQ_SIZE_WIDTH x 64-bit storage with 1 synchronous write port and 1 asynchronous read port, plus reset clear.
- Pointer/count control, bypass mux and flush logic live in instr_queue.

## Test plan
- Reset then fill: hold rst=0 for 2 cycles, then push 8 words (0x00000013 at 0x0, step 4). Required: count=8, queue_full=1, dec_instr=0x00000013, dec_addr=0; a 9th push is dropped.
- Wrap-around: push 6, pop 6, push 5. Required: tail wraps to 3, count=5, and the head addr is the first of the second batch.
- Simultaneous push+pop at count=8 with dec_issued=1 and fetch_valid=1. Required: pop occurs, push is blocked, count=7. With count=3 and both asserted, count stays 3.
- Flush with push and pop asserted at count=5. Required: count=0 and dec_ready=0 after the edge, and the pushed word is absent.
- rdy=0 for 4 cycles with fetch_valid and dec_issued toggling. Required: count, head and outputs unchanged.
- Compressed flag: push 0x00004501 (c.li). Required: dec_is_c=1. Then push 0x00100093. Required: dec_is_c=0 when it reaches head. With IQ_BYPASS_EN, an empty push plus same-cycle dec_issued leaves count=0.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared types and sizing for the instruction queue; IQ_SIZE_WIDTH and ROB_SIZE_WIDTH
// are global defines so the fetcher and RoB can size their own occupancy logic.
`ifndef IQ_SIZE_WIDTH
`define IQ_SIZE_WIDTH 3
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package instr_queue_pkg;

    localparam int IQ_SIZE_WIDTH_DEF = `IQ_SIZE_WIDTH;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } iq_entry_t;

    // RVC encodings are every opcode whose low two bits are not 2'b11.
    function automatic logic is_compressed(input logic [31:0] word);
        return word[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side and decode-side signals of the instruction queue.
// master = fetcher/decoder side, slave = the queue itself.
interface instr_queue_if
    import instr_queue_pkg::*;
#(
    parameter int IQ_SIZE_WIDTH = IQ_SIZE_WIDTH_DEF
);
    logic                     flush;
    logic                     fetch_valid;
    logic [31:0]              fetch_instr;
    logic [31:0]              fetch_addr;
    logic                     queue_full;
    logic                     dec_ready;
    logic [31:0]              dec_instr;
    logic [31:0]              dec_addr;
    logic                     dec_is_c;
    logic                     dec_issued;
    logic [IQ_SIZE_WIDTH:0]   count;

    modport master (
        output flush, fetch_valid, fetch_instr, fetch_addr, dec_issued,
        input  queue_full, dec_ready, dec_instr, dec_addr, dec_is_c, count
    );

    modport slave (
        input  flush, fetch_valid, fetch_instr, fetch_addr, dec_issued,
        output queue_full, dec_ready, dec_instr, dec_addr, dec_is_c, count
    );
endinterface

// File: rtl/instr_queue_iq_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port, cleared on reset.
// Write lands at the edge; read is combinational. No backpressure of its own.
module iq_ram
    import instr_queue_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  logic [AW-1:0] waddr,
    input  iq_entry_t wdat,
    input  logic [AW-1:0] raddr,
    output iq_entry_t rdat
);
    localparam int DEPTH = 1 << AW;

    iq_entry_t mem_q [DEPTH];
    iq_entry_t mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdat = mem_q[raddr];

endmodule

// File: rtl/instr_queue.sv
// Circular fetch->decode instruction buffer; 1-cycle push-to-head latency, 0 with IQ_BYPASS_EN.
// Backpressure: queue_full stalls the fetcher; decoder pops via dec_issued; flush empties it.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int IQ_SIZE_WIDTH = IQ_SIZE_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    instr_queue_if.slave bus
);
    localparam logic [IQ_SIZE_WIDTH:0]   FULL_CNT = {1'b1, {IQ_SIZE_WIDTH{1'b0}}};
    localparam logic [IQ_SIZE_WIDTH:0]   CNT_ONE  = {{IQ_SIZE_WIDTH{1'b0}}, 1'b1};
    localparam logic [IQ_SIZE_WIDTH-1:0] PTR_ONE  = {{(IQ_SIZE_WIDTH-1){1'b0}}, 1'b1};

    logic [IQ_SIZE_WIDTH-1:0] head_q, head_d;
    logic [IQ_SIZE_WIDTH-1:0] tail_q, tail_d;
    logic [IQ_SIZE_WIDTH:0]   count_q, count_d;

    logic      empty, full;
    logic      bypass, bypass_take;
    logic      push, pop;
    iq_entry_t head_ent;
    iq_entry_t wr_ent;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

`ifdef IQ_BYPASS_EN
    assign bypass = rdy && bus.fetch_valid && !bus.flush && empty;
`else
    assign bypass = 1'b0;
`endif
    // A bypassed word issued in the same cycle never occupies a slot.
    assign bypass_take = bypass && bus.dec_issued;

    assign push = rdy && bus.fetch_valid && !full && !bus.flush && !bypass_take;
    assign pop  = rdy && bus.dec_issued && !empty && !bus.flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy) begin
            if (bus.flush) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) tail_d = tail_q + PTR_ONE;
                if (pop)  head_d = head_q + PTR_ONE;
                unique case ({push, pop})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign wr_ent.instr = bus.fetch_instr;
    assign wr_ent.addr  = bus.fetch_addr;

    iq_ram #(
        .AW(IQ_SIZE_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (tail_q),
        .wdat  (wr_ent),
        .raddr (head_q),
        .rdat  (head_ent)
    );

    always_comb begin
        bus.dec_ready = !empty;
        bus.dec_instr = head_ent.instr;
        bus.dec_addr  = head_ent.addr;
        if (bypass) begin
            bus.dec_ready = 1'b1;
            bus.dec_instr = bus.fetch_instr;
            bus.dec_addr  = bus.fetch_addr;
        end
    end

    assign bus.dec_is_c   = is_compressed(bus.dec_instr);
    assign bus.queue_full = full;
    assign bus.count      = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Scenario bench for instr_queue with a queue-based scoreboard of issued entries.
module tb_instr_queue;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } ent_t;

    localparam int DEPTH = 8;
`ifdef IQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;
    logic rdy;

    instr_queue_if #(.IQ_SIZE_WIDTH(3)) bus ();

    instr_queue #(.IQ_SIZE_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        sb[$];
    int          checks;
    int          errors;
    int          proto_err;
    logic        pre_rdy;
    logic [31:0] pre_ins;

    // Drives one cycle, updates the scoreboard, and checks the head whenever it is issued.
    task automatic drive(input logic fv, input logic [31:0] ins, input logic [31:0] adr,
                         input logic iss, input logic fl, input logic r,
                         output logic o_rdy, output logic [31:0] o_ins);
        logic byp, do_pop, do_push;
        ent_t e;
        bus.fetch_valid = fv;
        bus.fetch_instr = ins;
        bus.fetch_addr  = adr;
        bus.dec_issued  = iss;
        bus.flush       = fl;
        rdy             = r;
        #2;
        o_rdy = bus.dec_ready;
        o_ins = bus.dec_instr;
        if (r && fv && bus.queue_full) proto_err++;
        byp     = BYPASS && r && fv && !fl && (sb.size() == 0);
        do_pop  = r && iss && !fl && (sb.size() > 0);
        do_push = r && fv && !fl && (sb.size() < DEPTH) && !(byp && iss);
        if (do_pop) begin
            e = sb.pop_front();
            checks++;
            if (bus.dec_instr !== e.instr || bus.dec_addr !== e.addr) begin
                errors++;
                $display("FAIL issue_head: got %h@%h, expected %h@%h",
                         bus.dec_instr, bus.dec_addr, e.instr, e.addr);
            end
        end else if (byp && iss) begin
            checks++;
            if (bus.dec_instr !== ins || bus.dec_addr !== adr) begin
                errors++;
                $display("FAIL bypass_head: got %h@%h, expected %h@%h",
                         bus.dec_instr, bus.dec_addr, ins, adr);
            end
        end
        if (r && fl) sb.delete();
        else if (do_push) sb.push_back('{ins, adr});
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] ins, input logic [31:0] adr);
        drive(1'b1, ins, adr, 1'b0, 1'b0, 1'b1, pre_rdy, pre_ins);
    endtask

    task automatic pop_word();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, pre_rdy, pre_ins);
    endtask

    task automatic do_reset();
        bus.fetch_valid = 1'b0;
        bus.fetch_instr = '0;
        bus.fetch_addr  = '0;
        bus.dec_issued  = 1'b0;
        bus.flush       = 1'b0;
        rdy             = 1'b1;
        rst             = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.count !== 4'd0 || bus.dec_ready !== 1'b0 || bus.queue_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: count=%0d ready=%b full=%b, expected 0/0/0",
                     bus.count, bus.dec_ready, bus.queue_full);
        end
        checks++;
        if (bus.dec_instr !== 32'h0 || bus.dec_addr !== 32'h0 || bus.dec_is_c !== 1'b1) begin
            errors++;
            $display("FAIL reset_head: instr=%h addr=%h is_c=%b, expected 0/0/1",
                     bus.dec_instr, bus.dec_addr, bus.dec_is_c);
        end
    endtask

    task automatic test_fill();
        proto_err = 0;
        for (int i = 0; i < 8; i++) push_word(32'h0000_0013, 32'(i * 4));
        checks++;
        if (bus.count !== 4'd8 || bus.queue_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_count: count=%0d full=%b, expected 8/1", bus.count, bus.queue_full);
        end
        checks++;
        if (bus.dec_instr !== 32'h0000_0013 || bus.dec_addr !== 32'h0) begin
            errors++;
            $display("FAIL fill_head: %h@%h, expected 00000013@00000000", bus.dec_instr, bus.dec_addr);
        end
        push_word(32'hDEAD_BEEF, 32'h20);
        checks++;
        if (bus.count !== 4'd8 || proto_err !== 1) begin
            errors++;
            $display("FAIL fill_overflow: count=%0d proto=%0d, expected 8/1", bus.count, proto_err);
        end
        for (int i = 0; i < 8; i++) pop_word();
        checks++;
        if (bus.count !== 4'd0 || bus.dec_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain: count=%0d ready=%b, expected 0/0", bus.count, bus.dec_ready);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 6; i++) push_word(32'h0000_0113 + 32'(i << 20), 32'h100 + 32'(i * 4));
        for (int i = 0; i < 6; i++) pop_word();
        for (int i = 0; i < 5; i++) push_word(32'h0000_0193 + 32'(i << 20), 32'h200 + 32'(i * 4));
        checks++;
        if (dut.tail_q !== 3'd3 || bus.count !== 4'd5) begin
            errors++;
            $display("FAIL wrap_ptr: tail=%0d count=%0d, expected 3/5", dut.tail_q, bus.count);
        end
        checks++;
        if (bus.dec_addr !== 32'h200) begin
            errors++;
            $display("FAIL wrap_head: addr=%h, expected 00000200", bus.dec_addr);
        end
        for (int i = 0; i < 5; i++) pop_word();
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 8; i++) push_word(32'h0000_0213 + 32'(i << 20), 32'h300 + 32'(i * 4));
        drive(1'b1, 32'hBAD0_0013, 32'h3F0, 1'b1, 1'b0, 1'b1, pre_rdy, pre_ins);
        checks++;
        if (bus.count !== 4'd7 || bus.queue_full !== 1'b0 || bus.dec_addr !== 32'h304) begin
            errors++;
            $display("FAIL full_pushpop: count=%0d full=%b addr=%h, expected 7/0/00000304",
                     bus.count, bus.queue_full, bus.dec_addr);
        end
        for (int i = 0; i < 4; i++) pop_word();
        drive(1'b1, 32'h0000_0293, 32'h3F4, 1'b1, 1'b0, 1'b1, pre_rdy, pre_ins);
        checks++;
        if (bus.count !== 4'd3 || bus.dec_addr !== 32'h318) begin
            errors++;
            $display("FAIL mid_pushpop: count=%0d addr=%h, expected 3/00000318", bus.count, bus.dec_addr);
        end
        for (int i = 0; i < 3; i++) pop_word();
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) push_word(32'h0000_0313 + 32'(i << 20), 32'h400 + 32'(i * 4));
        drive(1'b1, 32'hBAD1_0013, 32'h4F0, 1'b1, 1'b1, 1'b1, pre_rdy, pre_ins);
        checks++;
        if (bus.count !== 4'd0 || bus.dec_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: count=%0d ready=%b, expected 0/0", bus.count, bus.dec_ready);
        end
        push_word(32'h0000_0393, 32'h500);
        checks++;
        if (bus.count !== 4'd1 || bus.dec_instr !== 32'h0000_0393 || bus.dec_addr !== 32'h500) begin
            errors++;
            $display("FAIL flush_refill: count=%0d head=%h@%h, expected 1 00000393@00000500",
                     bus.count, bus.dec_instr, bus.dec_addr);
        end
        pop_word();
    endtask

    task automatic test_rdy_low();
        do_reset();
        for (int i = 0; i < 3; i++) push_word(32'h0000_0413 + 32'(i << 20), 32'h600 + 32'(i * 4));
        for (int i = 0; i < 4; i++)
            drive(1'(i % 2), 32'hBAD2_0013, 32'h6F0, 1'((i + 1) % 2), 1'b0, 1'b0, pre_rdy, pre_ins);
        checks++;
        if (bus.count !== 4'd3 || dut.head_q !== 3'd0 || bus.dec_addr !== 32'h600
            || bus.dec_instr !== 32'h0000_0413) begin
            errors++;
            $display("FAIL rdy_hold: count=%0d head=%0d addr=%h instr=%h, expected 3/0/00000600/00000413",
                     bus.count, dut.head_q, bus.dec_addr, bus.dec_instr);
        end
        for (int i = 0; i < 3; i++) pop_word();
    endtask

    task automatic test_compressed();
        do_reset();
        push_word(32'h0000_4501, 32'h700);
        checks++;
        if (bus.dec_is_c !== 1'b1 || bus.dec_instr !== 32'h0000_4501) begin
            errors++;
            $display("FAIL c_flag: is_c=%b instr=%h, expected 1/00004501", bus.dec_is_c, bus.dec_instr);
        end
        push_word(32'h0010_0093, 32'h702);
        pop_word();
        checks++;
        if (bus.dec_is_c !== 1'b0 || bus.dec_addr !== 32'h702) begin
            errors++;
            $display("FAIL full_flag: is_c=%b addr=%h, expected 0/00000702", bus.dec_is_c, bus.dec_addr);
        end
        pop_word();
        drive(1'b1, 32'h0000_4505, 32'h710, 1'b1, 1'b0, 1'b1, pre_rdy, pre_ins);
        checks++;
        if (pre_rdy !== BYPASS) begin
            errors++;
            $display("FAIL empty_visible: ready=%b, expected %b", pre_rdy, BYPASS);
        end
        checks++;
        if (bus.count !== (BYPASS ? 4'd0 : 4'd1)) begin
            errors++;
            $display("FAIL empty_issue_count: count=%0d, expected %0d", bus.count, BYPASS ? 0 : 1);
        end
        while (sb.size() > 0) pop_word();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        proto_err = 0;
        rst       = 1'b0;
        test_reset();
        test_fill();
        test_wrap();
        test_full_pushpop();
        test_flush();
        test_rdy_low();
        test_compressed();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
